// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-FF row sync, full-frame debounce and a
// single-key press FSM that emits one strobe per accepted key.
module keypad_scanner #(
  parameter int CLK_DIVIDER    = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key_onehot,
  output logic        key_valid,
  output logic        key_strobe
);

  localparam int DIV_W = $clog2(CLK_DIVIDER);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;

  // FSM state is a typed signal so checkers can bind to it by name
  state_t state, state_next;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      raw, last, debounced, raw_next;
  logic [CNT_W-1:0] stable_cnt;
  logic             tick, frame_close, is_one_hot;
  logic [15:0]      onehot_next;
  logic             strobe_next;

  assign tick        = (div_cnt == DIV_LAST);
  assign frame_close = tick && (col_idx == 2'd3);
  assign col_out     = ~(4'b0001 << col_idx);

  // Rows idle high (pull-ups), so the synchroniser resets to "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame as it will look once the current column's rows are merged in.
  always_comb begin
    raw_next = raw;
    for (int r = 0; r < 4; r++) begin
      raw_next[{2'(r), col_idx}] = ~row_sync[2'(r)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw        <= '0;
      last       <= '0;
      debounced  <= '0;
      stable_cnt <= '0;
    end else if (tick) begin
      raw <= raw_next;
      if (frame_close) begin
        if (raw_next != last) begin
          last       <= raw_next;
          stable_cnt <= CNT_W'(1);
        end else if (stable_cnt != CNT_MAX) begin
          stable_cnt <= stable_cnt + CNT_W'(1);
          if (stable_cnt + CNT_W'(1) == CNT_MAX) debounced <= raw_next;
        end
      end
    end
  end

  assign is_one_hot = (debounced != 16'd0) &&
                      ((debounced & (debounced - 16'd1)) == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      key_onehot <= onehot_next;
      key_valid  <= |onehot_next;
      key_strobe <= strobe_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (is_one_hot)               state_next = PRESSED;
        else if (debounced != 16'd0)  state_next = BLOCKED;
      end
      PRESSED: begin
        if (debounced == 16'd0)             state_next = IDLE;
        else if (debounced != key_onehot)   state_next = BLOCKED;
      end
      BLOCKED: begin
        if (debounced == 16'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Any change away from the held key (release, rollover, second key) clears the vector.
  always_comb begin
    onehot_next = key_onehot;
    strobe_next = 1'b0;
    case (state)
      IDLE: begin
        if (is_one_hot) begin
          onehot_next = debounced;
          strobe_next = 1'b1;
        end else begin
          onehot_next = '0;
        end
      end
      PRESSED: begin
        if (debounced != key_onehot) onehot_next = '0;
      end
      default: onehot_next = '0;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model driving row_in
// from col_out and a running strobe monitor.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        key_strobe;
  logic [15:0] pressed = 16'h0000;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int strobe_long = 0;
  logic prev_strobe = 1'b0;

  keypad_scanner #(.CLK_DIVIDER(4), .DEBOUNCE_SCANS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad: a held key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_strobe) strobe_cnt++;
    if (key_strobe && prev_strobe) strobe_long++;
    prev_strobe = key_strobe;
  end

  function automatic int encode(input logic [15:0] v);
    encode = -1;
    for (int i = 0; i < 16; i++) if (v[i]) encode = i;
  endfunction

  task automatic wait_strobe(input int budget, output int clks);
    clks = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        clks = i;
        break;
      end
    end
  endtask

  task automatic wait_release(input int budget, output int clks);
    clks = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!key_valid) begin
        clks = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    #2;
    vectors++; if (col_out !== 4'b1110) begin miscompares++; $display("FAIL reset_col: got %b want 1110", col_out); end
    vectors++; if (key_onehot !== 16'h0000) begin miscompares++; $display("FAIL reset_onehot: got %h want 0000", key_onehot); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    vectors++; if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b want 0", key_strobe); end
    repeat (2) @(negedge clk);
    vectors++; if (col_out !== 4'b1110) begin miscompares++; $display("FAIL reset_col_clocked: got %b want 1110", col_out); end
    rst_n = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      vectors++;
      if (col_out !== exp_col) begin
        miscompares++;
        $display("FAIL col_step[%0d]: got %b want %b", n, col_out, exp_col);
      end
    end
  endtask

  task automatic test_single_press;
    int base, clks;
    @(negedge clk);
    base = strobe_cnt;
    pressed = 16'h0200;
    wait_strobe(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL press_latency: got no strobe want strobe within 68 clk"); end
    vectors++; if (key_onehot !== 16'h0200) begin miscompares++; $display("FAIL press_onehot: got %h want 0200", key_onehot); end
    vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL press_valid: got %b want 1", key_valid); end
    vectors++; if (encode(key_onehot) !== 9) begin miscompares++; $display("FAIL press_encode: got %0d want 9", encode(key_onehot)); end
    @(negedge clk);
    vectors++; if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL press_strobe_width: got %b want 0", key_strobe); end
    repeat (48) @(negedge clk);
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL press_strobe_count: got %0d want 1", strobe_cnt - base); end
    vectors++; if (key_onehot !== 16'h0200) begin miscompares++; $display("FAIL press_hold: got %h want 0200", key_onehot); end
    pressed = 16'h0000;
    wait_release(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL press_release: got valid=%b want 0 within 68 clk", key_valid); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_bounce;
    int base, clks, guard;
    guard = 0;
    while (col_out !== 4'b0111 && guard < 20) begin @(negedge clk); guard++; end
    while (col_out !== 4'b1110 && guard < 30) begin @(negedge clk); guard++; end
    vectors++; if (col_out !== 4'b1110) begin miscompares++; $display("FAIL bounce_align: got %b want 1110", col_out); end
    repeat (9) @(negedge clk);
    base = strobe_cnt;
    pressed = 16'h0008;
    repeat (10) begin
      repeat (10) @(negedge clk);
      pressed = pressed ^ 16'h0008;
    end
    wait_strobe(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL bounce_strobe: got no strobe want one after settle"); end
    vectors++; if (key_onehot !== 16'h0008) begin miscompares++; $display("FAIL bounce_onehot: got %h want 0008", key_onehot); end
    repeat (40) @(negedge clk);
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL bounce_strobe_count: got %0d want 1", strobe_cnt - base); end
    pressed = 16'h0000;
    wait_release(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL bounce_release: got valid=%b want 0 within 68 clk", key_valid); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_multi_key;
    int base, clks;
    @(negedge clk);
    base = strobe_cnt;
    pressed = 16'h8001;
    repeat (80) @(negedge clk);
    vectors++; if (key_onehot !== 16'h0000) begin miscompares++; $display("FAIL multi_onehot: got %h want 0000", key_onehot); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL multi_valid: got %b want 0", key_valid); end
    vectors++; if (strobe_cnt - base !== 0) begin miscompares++; $display("FAIL multi_strobe: got %0d want 0", strobe_cnt - base); end
    pressed = 16'h0001;
    repeat (80) @(negedge clk);
    vectors++; if (key_onehot !== 16'h0000) begin miscompares++; $display("FAIL partial_release_onehot: got %h want 0000", key_onehot); end
    vectors++; if (strobe_cnt - base !== 0) begin miscompares++; $display("FAIL partial_release_strobe: got %0d want 0", strobe_cnt - base); end
    pressed = 16'h0000;
    repeat (80) @(negedge clk);
    pressed = 16'h0040;
    wait_strobe(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL after_block_strobe: got no strobe want strobe within 68 clk"); end
    vectors++; if (key_onehot !== 16'h0040) begin miscompares++; $display("FAIL after_block_onehot: got %h want 0040", key_onehot); end
    pressed = 16'h0000;
    wait_release(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL after_block_release: got valid=%b want 0 within 68 clk", key_valid); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_release;
    int base, clks;
    @(negedge clk);
    base = strobe_cnt;
    pressed = 16'h8000;
    wait_strobe(68, clks);
    vectors++; if (key_onehot !== 16'h8000) begin miscompares++; $display("FAIL r3c3_onehot: got %h want 8000", key_onehot); end
    repeat (4) @(negedge clk);
    pressed = 16'h0000;
    wait_release(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL r3c3_release: got valid=%b want 0 within 68 clk", key_valid); end
    vectors++; if (key_onehot !== 16'h0000) begin miscompares++; $display("FAIL r3c3_release_onehot: got %h want 0000", key_onehot); end
    repeat (20) @(negedge clk);
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL r3c3_strobe_count: got %0d want 1", strobe_cnt - base); end
  endtask

  task automatic test_reset_mid_hold;
    int base, clks;
    @(negedge clk);
    pressed = 16'h0010;
    wait_strobe(68, clks);
    vectors++; if (key_onehot !== 16'h0010) begin miscompares++; $display("FAIL pre_reset_onehot: got %h want 0010", key_onehot); end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (key_onehot !== 16'h0000) begin miscompares++; $display("FAIL async_reset_onehot: got %h want 0000", key_onehot); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: got %b want 0", key_valid); end
    vectors++; if (col_out !== 4'b1110) begin miscompares++; $display("FAIL async_reset_col: got %b want 1110", col_out); end
    @(negedge clk);
    base = strobe_cnt;
    rst_n = 1'b1;
    wait_strobe(68, clks);
    vectors++; if (clks < 0) begin miscompares++; $display("FAIL post_reset_strobe: got no strobe want strobe within 68 clk"); end
    vectors++; if (key_onehot !== 16'h0010) begin miscompares++; $display("FAIL post_reset_onehot: got %h want 0010", key_onehot); end
    repeat (20) @(negedge clk);
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL post_reset_strobe_count: got %0d want 1", strobe_cnt - base); end
    vectors++; if (strobe_long !== 0) begin miscompares++; $display("FAIL strobe_width_total: got %0d wide strobes want 0", strobe_long); end
    pressed = 16'h0000;
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_bounce;
    test_multi_key;
    test_release;
    test_reset_mid_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
